qpu_exu_tiq: RTL and testbench

Time-point queue sitting directly downstream of the execution write-back stage: it accepts the time-write-back beat (one entry per QWAIT / new time point) and paces the issue of time triggers to the event queue. Each entry is a relative delay; the block counts it down and emits a one-cycle trigger when it expires, giving cycle-exact spacing between successive time points. It also returns the not-full ready that the write-back stage folds into its time/event back-pressure.

---
 rtl/qpu_exu_tiq.sv | 198 +++++++++++++++++++
 tb/tb_qpu_exu_tiq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_exu_tiq.sv
// qpu_exu_tiq -- time-point queue behind the execution write-back stage.
//
// Each write-back time beat pushes one relative delay D. The head entry is
// loaded into a countdown register. When the count expires, a one-cycle
// trigger pops the head and paces the event queue. D is the number of
// non-trigger run cycles between entering COUNT (or the previous trigger)
// and the trigger.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tiq_wbck_i_ena    push strobe (already qualified with ready upstream)
//   tiq_wbck_i_data   delay value to push
//   tiq_wbck_i_ready  queue not full (combinational from occupancy)
//   tiq_run_i         1 = timing runs, 0 = paused (counter frozen)
//   tiq_flush_i       synchronous flush; overrides push and trigger
//   tiq_trig_o        one-cycle time trigger; pops the head entry
//   tiq_empty_o       queue holds no entries
//   tiq_count_o       number of stored entries
//   tiq_ovf_o         sticky: push attempted while full
//   tiq_state_o       debug view of the FSM (0 = IDLE, 1 = COUNT)
//
// Handshake: a beat transfers on a clock edge where tiq_wbck_i_ena is high
// and tiq_wbck_i_ready is high. Ready depends only on stored occupancy and
// ignores a same-cycle pop, so a full queue refuses a push even while it
// fires a trigger. An ena beat while not ready is dropped and sets ovf.

`ifndef QPU_TIME_WIDTH
`define QPU_TIME_WIDTH 32
`endif

module qpu_exu_tiq #(
    parameter int TIME_WIDTH = `QPU_TIME_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tiq_wbck_i_ena,
    input  logic [TIME_WIDTH-1:0]      tiq_wbck_i_data,
    output logic                       tiq_wbck_i_ready,
    input  logic                       tiq_run_i,
    input  logic                       tiq_flush_i,
    output logic                       tiq_trig_o,
    output logic                       tiq_empty_o,
    output logic [$clog2(DEPTH):0]     tiq_count_o,
    output logic                       tiq_ovf_o,
    output logic                       tiq_state_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Storage and occupancy
    // ------------------------------------------------------------------
    logic [TIME_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_ptr_nx;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  ovf;
    logic                  full;
    logic                  empty;
    logic                  push_ok;
    logic                  push_drop;
    logic                  pop;
    logic [TIME_WIDTH-1:0] head;
    logic [TIME_WIDTH-1:0] next_head;

    state_e                state;
    state_e                state_nxt;
    logic [TIME_WIDTH-1:0] cnt;
    logic [TIME_WIDTH-1:0] cnt_nxt;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign rd_ptr_nx = rd_ptr + 1'b1;
    assign head      = mem[rd_ptr];
    assign next_head = mem[rd_ptr_nx];

    // Flush cancels any write-back beat presented in the same cycle.
    assign push_ok   = tiq_wbck_i_ena & ~full & ~tiq_flush_i;
    assign push_drop = tiq_wbck_i_ena &  full & ~tiq_flush_i;
    assign pop       = tiq_trig_o;

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Array contents carry no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= tiq_wbck_i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (tiq_flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nx;
            end
            count <= count_nxt;
            if (push_drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Countdown FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (tiq_flush_i) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Countdown FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (tiq_run_i && !empty) begin
                    state_nxt = S_COUNT;
                    cnt_nxt   = head;
                end
            end
            S_COUNT: begin
                if (tiq_run_i) begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else if (count > CW'(1)) begin
                        // The entry behind the head is already stored, so chain
                        // straight into it. A push in this same cycle is not yet
                        // counted and is picked up from IDLE instead.
                        cnt_nxt = next_head;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Countdown FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        tiq_trig_o = 1'b0;
        if (state == S_COUNT && tiq_run_i && cnt == '0 && !tiq_flush_i) begin
            tiq_trig_o = 1'b1;
        end
    end

    assign tiq_wbck_i_ready = ~full;
    assign tiq_empty_o      = empty;
    assign tiq_count_o      = count;
    assign tiq_ovf_o        = ovf;
    assign tiq_state_o      = (state == S_COUNT);

endmodule

// File: tb/tb_qpu_exu_tiq.sv
// tb_qpu_exu_tiq -- directed, table-driven bench for qpu_exu_tiq.
// Each table row is one clock cycle: inputs driven just after the rising
// edge and expected outputs checked at the falling edge of the same cycle.
// A hand-written sequence covers asynchronous reset mid-count.

module tb_qpu_exu_tiq;

    localparam int TW = 8;
    localparam int DP = 8;
    localparam int CW = $clog2(DP) + 1;

    // clock / reset
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT signals
    logic          ena;
    logic [TW-1:0] data;
    logic          ready;
    logic          run;
    logic          flush;
    logic          trig;
    logic          empty;
    logic [CW-1:0] count;
    logic          ovf;
    logic          state_dbg;

    qpu_exu_tiq #(
        .TIME_WIDTH (TW),
        .DEPTH      (DP)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tiq_wbck_i_ena   (ena),
        .tiq_wbck_i_data  (data),
        .tiq_wbck_i_ready (ready),
        .tiq_run_i        (run),
        .tiq_flush_i      (flush),
        .tiq_trig_o       (trig),
        .tiq_empty_o      (empty),
        .tiq_count_o      (count),
        .tiq_ovf_o        (ovf),
        .tiq_state_o      (state_dbg)
    );

    // vector table
    typedef struct {
        bit            rst;
        bit            ena;
        logic [TW-1:0] data;
        bit            run;
        bit            flush;
        bit            trig;
        bit            empty;
        logic [CW-1:0] count;
        bit            ready;
        bit            ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    function automatic void add(bit r, bit e, int d, bit rn, bit f,
                                bit t, bit em, int c, bit rd, bit o);
        vec_t v;
        v.rst   = r;
        v.ena   = e;
        v.data  = TW'(d);
        v.run   = rn;
        v.flush = f;
        v.trig  = t;
        v.empty = em;
        v.count = CW'(c);
        v.ready = rd;
        v.ovf   = o;
        vecs.push_back(v);
    endfunction

    // driver tasks
    task automatic do_reset();
        ena   = 1'b0;
        data  = '0;
        run   = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // scoreboard compare
    task automatic check(input string name, input bit e_trig, input bit e_empty,
                         input logic [CW-1:0] e_count, input bit e_ready, input bit e_ovf);
        n_vec++;
        if ({trig, empty, count, ready, ovf} !== {e_trig, e_empty, e_count, e_ready, e_ovf}) begin
            n_err++;
            $display("FAIL %s: trig/empty/count/ready/ovf got %0b/%0b/%0d/%0b/%0b want %0b/%0b/%0d/%0b/%0b",
                     name, trig, empty, count, ready, ovf,
                     e_trig, e_empty, e_count, e_ready, e_ovf);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d3 [8];
        n_vec = 0;
        n_err = 0;
        ena   = 1'b0;
        data  = '0;
        run   = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        d3    = '{1, 0, 2, 0, 3, 1, 0, 2};

        // single push D=3 in cycle 0, run=1: trigger only in cycle 5
        //   r  e  d  run f   trig empty cnt rdy ovf
        add(1, 1, 3, 1, 0,   0,   1,   0,  1,  0);
        add(0, 0, 0, 1, 0,   0,   0,   1,  1,  0);
        add(0, 0, 0, 1, 0,   0,   0,   1,  1,  0);
        add(0, 0, 0, 1, 0,   0,   0,   1,  1,  0);
        add(0, 0, 0, 1, 0,   0,   0,   1,  1,  0);
        add(0, 0, 0, 1, 0,   1,   0,   1,  1,  0);
        add(0, 0, 0, 1, 0,   0,   1,   0,  1,  0);

        // D=0,2,0 back to back: triggers in cycles 2, 5, 6
        add(1, 1, 0, 1, 0,   0,   1,   0,  1,  0);
        add(0, 1, 2, 1, 0,   0,   0,   1,  1,  0);
        add(0, 1, 0, 1, 0,   1,   0,   2,  1,  0);
        add(0, 0, 0, 1, 0,   0,   0,   2,  1,  0);
        add(0, 0, 0, 1, 0,   0,   0,   2,  1,  0);
        add(0, 0, 0, 1, 0,   1,   0,   2,  1,  0);
        add(0, 0, 0, 1, 0,   1,   0,   1,  1,  0);
        add(0, 0, 0, 1, 0,   0,   1,   0,  1,  0);

        // fill 8 entries paused, 9th push dropped, then drain in order
        for (int i = 0; i < 8; i++) begin
            add(i == 0, 1, d3[i], 0, 0,   0, i == 0, i, 1, 0);
        end
        add(0, 1, 7, 0, 0,   0,   0,   8,  0,  0);   // c8: dropped
        add(0, 0, 0, 0, 0,   0,   0,   8,  0,  1);   // c9: ovf visible
        add(0, 0, 0, 1, 0,   0,   0,   8,  0,  1);   // c10: load D=1
        add(0, 0, 0, 1, 0,   0,   0,   8,  0,  1);
        add(0, 0, 0, 1, 0,   1,   0,   8,  0,  1);   // c12: trig, still full
        add(0, 0, 0, 1, 0,   1,   0,   7,  1,  1);   // c13: D=0
        add(0, 0, 0, 1, 0,   0,   0,   6,  1,  1);
        add(0, 0, 0, 1, 0,   0,   0,   6,  1,  1);
        add(0, 0, 0, 1, 0,   1,   0,   6,  1,  1);   // c16: D=2
        add(0, 0, 0, 1, 0,   1,   0,   5,  1,  1);   // c17: D=0
        add(0, 0, 0, 1, 0,   0,   0,   4,  1,  1);
        add(0, 0, 0, 1, 0,   0,   0,   4,  1,  1);
        add(0, 0, 0, 1, 0,   0,   0,   4,  1,  1);
        add(0, 0, 0, 1, 0,   1,   0,   4,  1,  1);   // c21: D=3
        add(0, 0, 0, 1, 0,   0,   0,   3,  1,  1);
        add(0, 0, 0, 1, 0,   1,   0,   3,  1,  1);   // c23: D=1
        add(0, 0, 0, 1, 0,   1,   0,   2,  1,  1);   // c24: D=0
        add(0, 0, 0, 1, 0,   0,   0,   1,  1,  1);
        add(0, 0, 0, 1, 0,   0,   0,   1,  1,  1);
        add(0, 0, 0, 1, 0,   1,   0,   1,  1,  1);   // c27: D=2
        add(0, 0, 0, 1, 0,   0,   1,   0,  1,  1);
        // flush in the would-trigger cycle with a push: clears ovf too
        add(0, 1, 1, 1, 0,   0,   1,   0,  1,  1);
        add(0, 0, 0, 1, 0,   0,   0,   1,  1,  1);
        add(0, 0, 0, 1, 0,   0,   0,   1,  1,  1);
        add(0, 1, 4, 1, 1,   0,   0,   1,  1,  1);   // flush + push
        add(0, 0, 0, 1, 0,   0,   1,   0,  1,  0);
        add(0, 0, 0, 1, 0,   0,   1,   0,  1,  0);
        add(0, 0, 0, 1, 0,   0,   1,   0,  1,  0);

        // D=5 with pauses: 3 cycles mid-count, 1 cycle at expiry
        add(1, 1, 5, 1, 0,   0,   1,   0,  1,  0);
        add(0, 0, 0, 1, 0,   0,   0,   1,  1,  0);
        add(0, 0, 0, 1, 0,   0,   0,   1,  1,  0);
        add(0, 0, 0, 1, 0,   0,   0,   1,  1,  0);
        add(0, 0, 0, 0, 0,   0,   0,   1,  1,  0);
        add(0, 0, 0, 0, 0,   0,   0,   1,  1,  0);
        add(0, 0, 0, 0, 0,   0,   0,   1,  1,  0);
        add(0, 0, 0, 1, 0,   0,   0,   1,  1,  0);
        add(0, 0, 0, 1, 0,   0,   0,   1,  1,  0);
        add(0, 0, 0, 1, 0,   0,   0,   1,  1,  0);
        add(0, 0, 0, 0, 0,   0,   0,   1,  1,  0);   // paused at expiry
        add(0, 0, 0, 1, 0,   1,   0,   1,  1,  0);
        add(0, 0, 0, 1, 0,   0,   1,   0,  1,  0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                do_reset();
            end
            @(posedge clk);
            #1;
            ena   = vecs[i].ena;
            data  = vecs[i].data;
            run   = vecs[i].run;
            flush = vecs[i].flush;
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].trig, vecs[i].empty,
                  vecs[i].count, vecs[i].ready, vecs[i].ovf);
        end

        // asynchronous reset mid-COUNT with 4 entries stored
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            ena  = 1'b1;
            data = TW'(2);
            run  = 1'b0;
        end
        @(posedge clk);
        #1;
        ena = 1'b0;
        run = 1'b1;
        @(negedge clk);
        check("rst_setup", 1'b0, 1'b0, CW'(4), 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 1'b0, 1'b1, CW'(0), 1'b1, 1'b0);
        n_vec++;
        if (state_dbg !== 1'b0) begin
            n_err++;
            $display("FAIL rst_state: state got %0b want 0", state_dbg);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("post_rst%0d", i), 1'b0, 1'b1, CW'(0), 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
